// File: rtl/guess_pkg.sv
// Shared definitions for the guessing-game round controller.
//
// Contents:
//   - state encoding localparams and the state_t enum built on them
//   - LFSR seed and Fibonacci tap mask (x^8 + x^6 + x^5 + x^4 + 1)
//   - lfsr_next: one shift of the 8-bit LFSR
//   - cnt_width: counter width for a cycle-count parameter, never below 1 bit
package guess_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_SHOW       = 3'd1;
    localparam logic [2:0] ST_WAIT_GUESS = 3'd2;
    localparam logic [2:0] ST_WIN        = 3'd3;
    localparam logic [2:0] ST_LOSE       = 3'd4;

    typedef enum logic [2:0] {
        IDLE       = ST_IDLE,
        SHOW       = ST_SHOW,
        WAIT_GUESS = ST_WAIT_GUESS,
        WIN        = ST_WIN,
        LOSE       = ST_LOSE
    } state_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Bits 7,5,4,3 correspond to the polynomial terms x^8, x^6, x^5, x^4.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Shift left and feed the XOR of the tapped bits into bit 0. A nonzero
    // seed with this maximal-length polynomial never reaches the all-zero state.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

    // Width needed to count 0..n-1; a parameter of 1 still gets a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce_edge.sv
// Button conditioner: 2-FF synchronizer, stability debounce and rising-edge pulse.
//
// Ports:
//   clk    in  1  system clock
//   rst_n  in  1  asynchronous active-low reset
//   btn    in  1  raw, asynchronous button level
//   pulse  out 1  one-cycle pulse when a new high level is accepted
//
// A changed level must be seen on DEBOUNCE_CYCLES consecutive synchronized
// samples before it is accepted. The pulse is registered together with the
// accepted level, so a clean press shows up 2 + DEBOUNCE_CYCLES cycles later.
module btn_debounce_edge
    import guess_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    localparam int unsigned       CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Synchronize the raw button into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Count consecutive samples that disagree with the accepted level; any
    // agreeing sample restarts the count, so bouncing never gets through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
                pulse <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/guess_round_controller.sv
// Round controller for the one-hot LED guessing game.
//
// Picks a pseudo-random 4-bit secret, reveals it with a blink for a fixed
// window, then judges up to MAX_TRIES guesses and reports hints and result.
//
// Ports:
//   clk         in   1  system clock
//   rst_n       in   1  asynchronous active-low reset
//   btn_start   in   1  raw start button
//   btn_submit  in   1  raw submit button
//   guess       in   4  player guess from switches
//   system_val  out  4  current secret, to the display stage
//   show_en     out  1  display should show system_val
//   blink       out  1  blink phase during reveal, 1 otherwise
//   too_high    out  1  last wrong guess was above the secret
//   too_low     out  1  last wrong guess was below the secret
//   win         out  1  round won
//   lose        out  1  round lost
//   tries_left  out  2  remaining guesses this round
module guess_round_controller
    import guess_pkg::*;
#(
    parameter int unsigned SHOW_CYCLES     = 100_000_000,
    parameter int unsigned BLINK_HALF      = 25_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned MAX_TRIES       = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_submit,
    input  logic [3:0] guess,
    output logic [3:0] system_val,
    output logic       show_en,
    output logic       blink,
    output logic       too_high,
    output logic       too_low,
    output logic       win,
    output logic       lose,
    output logic [1:0] tries_left
);

    localparam int unsigned        SHOW_W     = cnt_width(SHOW_CYCLES);
    localparam int unsigned        BLINK_W    = cnt_width(BLINK_HALF);
    localparam logic [SHOW_W-1:0]  SHOW_LAST  = SHOW_W'(SHOW_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
    localparam logic [1:0]         TRIES_INIT = 2'(MAX_TRIES);

    logic start_p;
    logic submit_p;

    state_t             state,      state_n;
    logic [7:0]         lfsr;
    logic [3:0]         system_val_n;
    logic               show_en_n;
    logic               blink_n;
    logic               too_high_n;
    logic               too_low_n;
    logic               win_n;
    logic               lose_n;
    logic [1:0]         tries_left_n;
    logic [SHOW_W-1:0]  show_cnt,   show_cnt_n;
    logic [BLINK_W-1:0] blink_cnt,  blink_cnt_n;

    btn_debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_start),
        .pulse (start_p)
    );

    btn_debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_submit_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_submit),
        .pulse (submit_p)
    );

    // State and output registers. The LFSR free-runs every cycle so the
    // secret depends on when the player presses start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lfsr       <= LFSR_SEED;
            system_val <= 4'd0;
            show_en    <= 1'b0;
            blink      <= 1'b1;
            too_high   <= 1'b0;
            too_low    <= 1'b0;
            win        <= 1'b0;
            lose       <= 1'b0;
            tries_left <= 2'd0;
            show_cnt   <= '0;
            blink_cnt  <= '0;
        end else begin
            state      <= state_n;
            lfsr       <= lfsr_next(lfsr);
            system_val <= system_val_n;
            show_en    <= show_en_n;
            blink      <= blink_n;
            too_high   <= too_high_n;
            too_low    <= too_low_n;
            win        <= win_n;
            lose       <= lose_n;
            tries_left <= tries_left_n;
            show_cnt   <= show_cnt_n;
            blink_cnt  <= blink_cnt_n;
        end
    end

    // Next-state and next-output logic. Everything holds unless a state
    // explicitly changes it; start wins over submit outside WAIT_GUESS because
    // submit is simply never looked at there.
    always_comb begin
        state_n      = state;
        system_val_n = system_val;
        show_en_n    = show_en;
        blink_n      = blink;
        too_high_n   = too_high;
        too_low_n    = too_low;
        win_n        = win;
        lose_n       = lose;
        tries_left_n = tries_left;
        show_cnt_n   = show_cnt;
        blink_cnt_n  = blink_cnt;

        case (state)
            IDLE, WIN, LOSE: begin
                if (start_p) begin
                    state_n      = SHOW;
                    system_val_n = lfsr[3:0];
                    tries_left_n = TRIES_INIT;
                    too_high_n   = 1'b0;
                    too_low_n    = 1'b0;
                    win_n        = 1'b0;
                    lose_n       = 1'b0;
                    show_cnt_n   = '0;
                    blink_cnt_n  = '0;
                    show_en_n    = 1'b1;
                    blink_n      = 1'b1;
                end
            end

            SHOW: begin
                show_cnt_n = show_cnt + 1'b1;
                if (blink_cnt == BLINK_LAST) begin
                    blink_n     = ~blink;
                    blink_cnt_n = '0;
                end else begin
                    blink_cnt_n = blink_cnt + 1'b1;
                end
                if (show_cnt == SHOW_LAST) begin
                    state_n     = WAIT_GUESS;
                    show_en_n   = 1'b0;
                    blink_n     = 1'b1;
                    show_cnt_n  = '0;
                    blink_cnt_n = '0;
                end
            end

            WAIT_GUESS: begin
                if (submit_p) begin
                    if (guess == system_val) begin
                        state_n    = WIN;
                        win_n      = 1'b1;
                        too_high_n = 1'b0;
                        too_low_n  = 1'b0;
                        show_en_n  = 1'b1;
                        blink_n    = 1'b1;
                    end else begin
                        too_high_n = (guess > system_val);
                        too_low_n  = (guess < system_val);
                        if (tries_left != 2'd0) begin
                            tries_left_n = tries_left - 2'd1;
                        end
                        // The zero case cannot occur in a normal round; treating
                        // it as a loss keeps the FSM from getting stuck.
                        if (tries_left <= 2'd1) begin
                            state_n   = LOSE;
                            lose_n    = 1'b1;
                            show_en_n = 1'b1;
                            blink_n   = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_guess_round_controller.sv
// Directed testbench for guess_round_controller with short timing parameters.
// The bench keeps its own copy of the LFSR to predict and check the secret.
module tb_guess_round_controller;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b1;
    logic       btn_start  = 1'b0;
    logic       btn_submit = 1'b0;
    logic [3:0] guess      = 4'd0;
    logic [3:0] system_val;
    logic       show_en;
    logic       blink;
    logic       too_high;
    logic       too_low;
    logic       win;
    logic       lose;
    logic [1:0] tries_left;

    int checks   = 0;
    int failures = 0;

    logic [7:0] model_lfsr;

    guess_round_controller #(
        .SHOW_CYCLES     (8),
        .BLINK_HALF      (2),
        .DEBOUNCE_CYCLES (4),
        .MAX_TRIES       (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_start  (btn_start),
        .btn_submit (btn_submit),
        .guess      (guess),
        .system_val (system_val),
        .show_en    (show_en),
        .blink      (blink),
        .too_high   (too_high),
        .too_low    (too_low),
        .win        (win),
        .lose       (lose),
        .tries_left (tries_left)
    );

    always #5 clk = ~clk;

    // Reference LFSR: x^8 + x^6 + x^5 + x^4 + 1, seeded 8'hA5, shifting left.
    function automatic logic [7:0] model_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_lfsr <= 8'hA5;
        else        model_lfsr <= model_step(model_lfsr);
    end

    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press start (optionally with submit) so the captured secret is 'target',
    // then wait for the round to begin. A press at a negedge produces a pulse
    // 6 edges later, and the capture happens on the 7th edge using the LFSR
    // value from the pulse cycle. Returns at the first SHOW cycle.
    task automatic apply_stimulus_start(input bit use_target, input logic [3:0] target,
                                        input bit with_submit);
        logic [7:0] ahead;
        logic [7:0] prev;
        int         lat;
        bit         found;
        if (use_target) begin
            found = 1'b0;
            for (int i = 0; i < 300 && !found; i++) begin
                ahead = model_lfsr;
                repeat (6) ahead = model_step(ahead);
                if (ahead[3:0] == target) found = 1'b1;
                else @(negedge clk);
            end
            check_output("target_found", {7'd0, found}, 8'd1);
        end
        btn_start = 1'b1;
        if (with_submit) btn_submit = 1'b1;
        lat  = 0;
        prev = model_lfsr;
        while (!(show_en === 1'b1 && tries_left === 2'd3 && win === 1'b0 && lose === 1'b0)
               && lat < 20) begin
            prev = model_lfsr;
            @(negedge clk);
            lat++;
        end
        check_output("start_latency", 8'(lat), 8'd7);
        check_output("secret_vs_model", {4'd0, system_val}, {4'd0, prev[3:0]});
        if (use_target) check_output("secret_target", {4'd0, system_val}, {4'd0, target});
        btn_start  = 1'b0;
        btn_submit = 1'b0;
    endtask

    // Clean submit press: held long enough for one pulse, then released and
    // given time for the release to settle.
    task automatic apply_stimulus_submit(input logic [3:0] g);
        guess      = g;
        btn_submit = 1'b1;
        tick(7);
        btn_submit = 1'b0;
        tick(8);
    endtask

    bit blink_pat [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        // Reset
        #1 rst_n = 1'b0;
        tick(3);
        check_output("rst_system_val", {4'd0, system_val}, 8'd0);
        check_output("rst_show_en",    {7'd0, show_en},    8'd0);
        check_output("rst_blink",      {7'd0, blink},      8'd1);
        check_output("rst_too_high",   {7'd0, too_high},   8'd0);
        check_output("rst_too_low",    {7'd0, too_low},    8'd0);
        check_output("rst_win",        {7'd0, win},        8'd0);
        check_output("rst_lose",       {7'd0, lose},       8'd0);
        check_output("rst_tries_left", {6'd0, tries_left}, 8'd0);
        rst_n = 1'b1;
        tick(2);
        check_output("idle_show_en", {7'd0, show_en}, 8'd0);

        // Round 1: secret 9, reveal window and a win on the second guess
        apply_stimulus_start(1'b1, 4'h9, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check_output($sformatf("reveal_show_en_%0d", i), {7'd0, show_en}, 8'd1);
            check_output($sformatf("reveal_blink_%0d", i),   {7'd0, blink},   {7'd0, blink_pat[i]});
            tick(1);
        end
        check_output("reveal_end_show_en", {7'd0, show_en}, 8'd0);
        check_output("reveal_end_blink",   {7'd0, blink},   8'd1);

        apply_stimulus_submit(4'h3);
        check_output("win_g1_too_low",  {7'd0, too_low},    8'd1);
        check_output("win_g1_too_high", {7'd0, too_high},   8'd0);
        check_output("win_g1_tries",    {6'd0, tries_left}, 8'd2);
        check_output("win_g1_win",      {7'd0, win},        8'd0);
        apply_stimulus_submit(4'h9);
        check_output("win_win",      {7'd0, win},        8'd1);
        check_output("win_too_low",  {7'd0, too_low},    8'd0);
        check_output("win_too_high", {7'd0, too_high},   8'd0);
        check_output("win_show_en",  {7'd0, show_en},    8'd1);
        check_output("win_blink",    {7'd0, blink},      8'd1);
        check_output("win_tries",    {6'd0, tries_left}, 8'd2);

        // Round 2: secret 2, three high guesses lose the round
        apply_stimulus_start(1'b1, 4'h2, 1'b0);
        check_output("r2_win_cleared", {7'd0, win}, 8'd0);
        tick(8);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus_submit(4'hF);
            check_output($sformatf("lose_too_high_%0d", i), {7'd0, too_high},   8'd1);
            check_output($sformatf("lose_too_low_%0d", i),  {7'd0, too_low},    8'd0);
            check_output($sformatf("lose_tries_%0d", i),    {6'd0, tries_left}, 8'(2 - i));
            check_output($sformatf("lose_flag_%0d", i),     {7'd0, lose},       (i == 2) ? 8'd1 : 8'd0);
        end
        check_output("lose_show_en", {7'd0, show_en}, 8'd1);
        apply_stimulus_submit(4'hF);
        check_output("lose_extra_tries", {6'd0, tries_left}, 8'd0);
        check_output("lose_extra_lose",  {7'd0, lose},       8'd1);
        check_output("lose_extra_show",  {7'd0, show_en},    8'd1);

        // Round 3: secret 5, bouncing submit must not register
        apply_stimulus_start(1'b1, 4'h5, 1'b0);
        check_output("r3_lose_cleared", {7'd0, lose},     8'd0);
        check_output("r3_hint_cleared", {7'd0, too_high}, 8'd0);
        tick(8);
        guess = 4'h0;
        for (int i = 0; i < 10; i++) begin
            btn_submit = (i % 2 == 0);
            tick(2);
        end
        check_output("bounce_tries",   {6'd0, tries_left}, 8'd3);
        check_output("bounce_too_low", {7'd0, too_low},    8'd0);
        btn_submit = 1'b1;
        tick(6);
        btn_submit = 1'b0;
        tick(10);
        check_output("held_tries",   {6'd0, tries_left}, 8'd2);
        check_output("held_too_low", {7'd0, too_low},    8'd1);

        // Win, then start and submit together: start wins, no judgement
        apply_stimulus_submit(4'h5);
        check_output("r3_win", {7'd0, win}, 8'd1);
        guess = 4'h0;
        apply_stimulus_start(1'b1, 4'h6, 1'b1);
        check_output("prio_win",      {7'd0, win},        8'd0);
        check_output("prio_too_low",  {7'd0, too_low},    8'd0);
        check_output("prio_too_high", {7'd0, too_high},   8'd0);
        tick(3);
        check_output("prio_tries",   {6'd0, tries_left}, 8'd3);
        check_output("prio_show_en", {7'd0, show_en},    8'd1);

        // Reset mid-SHOW takes effect without waiting for a clock edge
        rst_n = 1'b0;
        #1;
        check_output("async_rst_show_en", {7'd0, show_en},    8'd0);
        check_output("async_rst_blink",   {7'd0, blink},      8'd1);
        check_output("async_rst_secret",  {4'd0, system_val}, 8'd0);
        check_output("async_rst_tries",   {6'd0, tries_left}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);
        check_output("post_rst_show_en", {7'd0, show_en}, 8'd0);

        // LFSR reseeded: an untargeted start must still match the model
        apply_stimulus_start(1'b0, 4'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
